// File: rtl/bin2qdi_1of3_tx.sv
`default_nettype none
// ============================================================================
// Module   : bin2qdi_1of3_tx
// Function : Clocked-to-QDI transmitter. Buffers 2-bit binary symbols from a
//            valid/ready source in a small FIFO and emits each one as an
//            e1of3 code using a four-phase return-to-zero handshake against
//            an asynchronous right enable (Re).
// Revision : 1.0 - initial release
// ============================================================================
module bin2qdi_1of3_tx #(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [1:0]               din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err,
   output logic [2:0]               R,
   input  logic                     Re,
   inout  wire                      VDD,
   inout  wire                      GND
);

   localparam int               c_aw    = $clog2(DEPTH);
   localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2
   } state_t;

   state_t                  r_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic [1:0]              r_mem [DEPTH];
   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_aw:0]           r_count;
   logic                    r_err;
   logic [2:0]              r_rails;

   logic                    w_re_s;
   logic                    w_ready;
   logic                    w_illegal;
   logic                    w_push;
   logic                    w_pop;

   // Binary symbol to e1of3 rail code; 11 is never stored, so it maps to null.
   function automatic logic [2:0] f_onehot(input logic [1:0] sym);
      logic [2:0] code;
      case (sym)
         2'b00:   code = 3'b001;
         2'b01:   code = 3'b010;
         2'b10:   code = 3'b100;
         default: code = 3'b000;
      endcase
      return code;
   endfunction

   assign w_re_s    = r_sync[SYNC_STAGES-1];
   // Ready is a pure function of the registered count: no bypass on a pop.
   assign w_ready   = (r_count < c_depth);
   assign w_illegal = din_valid && (din == 2'b11);
   assign w_push    = din_valid && w_ready && (din != 2'b11);
   assign w_pop     = (r_state == ST_IDLE) && (r_count != '0) && w_re_s;

   assign din_ready = w_ready;
   assign count     = r_count;
   assign err       = r_err;
   assign R         = r_rails;

   // Bring the asynchronous Re into the clock domain through a flop chain.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], Re};
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky flag for an illegal 11 symbol; only reset clears it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_err <= 1'b0;
      end else if (w_illegal) begin
         r_err <= 1'b1;
      end
   end

   // Four-phase handshake: raise one rail, wait for Re low, return to null,
   // wait for Re high. Re falling outside DATA is ignored.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_rails <= 3'b000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_rails <= f_onehot(r_mem[r_rd_ptr]);
                  r_state <= ST_DATA;
               end else begin
                  r_rails <= 3'b000;
               end
            end
            ST_DATA: begin
               if (!w_re_s) begin
                  r_rails <= 3'b000;
                  r_state <= ST_NULL;
               end
            end
            ST_NULL: begin
               r_rails <= 3'b000;
               if (w_re_s) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_rails <= 3'b000;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bin2qdi_1of3_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2qdi_1of3_tx
// Function : Self-checking bench for bin2qdi_1of3_tx. A symbol queue plus a
//            Re delay line predict rails, occupancy, ready and err each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2qdi_1of3_tx;

   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;

   logic                    CLK   = 1'b0;
   logic                    RESET = 1'b0;
   logic [1:0]              din   = 2'b00;
   logic                    din_valid = 1'b0;
   logic                    Re    = 1'b0;
   wire                     din_ready;
   wire [$clog2(DEPTH):0]   count;
   wire                     err;
   wire [2:0]               R;
   wire                     VDD;
   wire                     GND;

   assign VDD = 1'b1;
   assign GND = 1'b0;

   bin2qdi_1of3_tx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .count     (count),
      .err       (err),
      .R         (R),
      .Re        (Re),
      .VDD       (VDD),
      .GND       (GND)
   );

   always #5 CLK = ~CLK;

   int         n_cmp = 0;
   int         n_err = 0;

   // Reference state: queued symbols, expected rails, waiting-for-Re-high flag,
   // sticky error, and the Re values still travelling through the synchroniser.
   int         q[$];
   logic [2:0] m_rails;
   bit         m_rearm;
   bit         m_err;
   bit         re_line[$];

   logic [2:0] codes[$];
   logic [2:0] r_prev = 3'b000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rails = 3'b000;
      m_rearm = 1'b0;
      m_err   = 1'b0;
      re_line.delete();
      for (int i = 0; i < SYNC_STAGES; i++) re_line.push_back(1'b0);
   endtask

   // One clock edge: advance the reference, then compare every output.
   task automatic step();
      bit rs;
      int pre;
      @(posedge CLK);
      if (RESET) begin
         model_reset();
      end else begin
         rs  = re_line[0];
         pre = q.size();
         if (m_rails != 3'b000) begin
            if (!rs) begin
               m_rails = 3'b000;
               m_rearm = 1'b1;
            end
         end else if (m_rearm) begin
            if (rs) m_rearm = 1'b0;
         end else if (pre > 0 && rs) begin
            m_rails = 3'(3'b001 << q.pop_front());
         end
         if (din_valid && din == 2'b11) m_err = 1'b1;
         else if (din_valid && pre < DEPTH) q.push_back(int'(din));
         void'(re_line.pop_front());
         re_line.push_back(Re);
      end
      #1;
      chk("rails",     R,         m_rails);
      chk("count",     count,     q.size());
      chk("din_ready", din_ready, q.size() < DEPTH);
      chk("err",       err,       m_err);
      chk("onehot",    $countones(R) <= 1, 1);
      if (R !== r_prev && R != 3'b000) begin
         chk("null_sep", r_prev, 3'b000);
         codes.push_back(R);
      end
      r_prev = R;
   endtask

   // Offer one symbol until taken (11 is always consumed), bounded wait.
   task automatic push_sym(input logic [1:0] s, input bit auto_re);
      bit acc;
      bit done;
      done      = 1'b0;
      din       = s;
      din_valid = 1'b1;
      for (int t = 0; t < 60 && !done; t++) begin
         acc = din_ready || (s == 2'b11);
         step();
         if (auto_re) Re = (R == 3'b000);
         if (acc) done = 1'b1;
      end
      din_valid = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic run_auto(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         Re = (R == 3'b000);
      end
   endtask

   task automatic check_codes(input string tag, input logic [2:0] exp[$]);
      chk({tag, "_n"}, codes.size(), exp.size());
      for (int i = 0; i < codes.size() && i < exp.size(); i++) chk(tag, codes[i], exp[i]);
      codes.delete();
   endtask

   task automatic do_reset();
      #3 RESET = 1'b1;
      #1;
      chk("rst_rails", R, 3'b000);
      chk("rst_count", count, 0);
      chk("rst_err",   err, 0);
      model_reset();
      r_prev = 3'b000;
      step();
      step();
      @(negedge CLK) RESET = 1'b0;
   endtask

   initial begin
      logic [2:0] exp_c[$];
      model_reset();
      #1 RESET = 1'b1;
      #2;
      chk("init_rails", R, 3'b000);
      chk("init_count", count, 0);
      chk("init_ready", din_ready, 1);
      chk("init_err",   err, 0);
      step();
      step();
      @(negedge CLK) RESET = 1'b0;

      // Single symbol with Re already high.
      Re = 1'b1;
      repeat (3) step();
      din = 2'b01; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();
      chk("t1_rails", R, 3'b010);
      Re = 1'b0;
      repeat (3) step();
      chk("t1_null", R, 3'b000);
      Re = 1'b1;
      repeat (4) step();
      chk("t1_count", count, 0);
      codes.delete();

      // Ordered stream with an instantly responding QDI side.
      push_sym(2'b00, 1'b1);
      push_sym(2'b01, 1'b1);
      push_sym(2'b10, 1'b1);
      push_sym(2'b00, 1'b1);
      run_auto(40);
      exp_c = '{3'b001, 3'b010, 3'b100, 3'b001};
      check_codes("t2_code", exp_c);

      // Backpressure: Re held low, fifth symbol waits upstream.
      Re = 1'b0;
      repeat (3) step();
      push_sym(2'b10, 1'b0);
      push_sym(2'b00, 1'b0);
      push_sym(2'b01, 1'b0);
      push_sym(2'b10, 1'b0);
      chk("t3_count", count, 4);
      chk("t3_ready", din_ready, 0);
      din = 2'b01; din_valid = 1'b1;
      repeat (3) step();
      chk("t3_held", count, 4);
      Re = 1'b1;
      for (int t = 0; t < 60 && din_valid; t++) begin
         if (din_ready) begin
            step();
            din_valid = 1'b0;
         end else begin
            step();
         end
         Re = (R == 3'b000);
      end
      run_auto(60);
      exp_c = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b010};
      check_codes("t3_code", exp_c);

      // Illegal symbol between two legal ones.
      push_sym(2'b10, 1'b1);
      push_sym(2'b11, 1'b1);
      chk("t4_err", err, 1);
      push_sym(2'b01, 1'b1);
      run_auto(30);
      exp_c = '{3'b100, 3'b010};
      check_codes("t4_code", exp_c);

      // Reset while a code is on the rails with two symbols queued.
      Re = 1'b1;
      repeat (3) step();
      push_sym(2'b10, 1'b0);
      push_sym(2'b00, 1'b0);
      push_sym(2'b01, 1'b0);
      step();
      chk("t5_rails", R, 3'b100);
      chk("t5_count", count, 2);
      do_reset();
      Re = 1'b1;
      repeat (8) step();
      chk("t5_quiet", R, 3'b000);
      codes.delete();

      // Push lands on the same edge as a pop with two entries queued.
      Re = 1'b0;
      repeat (3) step();
      push_sym(2'b01, 1'b0);
      push_sym(2'b10, 1'b0);
      Re = 1'b1;
      step();
      step();
      din = 2'b00; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      chk("t6_count", count, 2);
      chk("t6_rails", R, 3'b010);
      run_auto(40);
      exp_c = '{3'b010, 3'b100, 3'b001};
      check_codes("t6_code", exp_c);

      // Randomised traffic: responsive or erratic Re, occasional 11, one reset.
      for (int seg = 0; seg < 16; seg++) begin
         bit erratic;
         erratic = ($urandom_range(0, 2) == 0);
         if (seg == 9) do_reset();
         for (int c = 0; c < 100; c++) begin
            din_valid = ($urandom_range(0, 2) != 0);
            din = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step();
            if (erratic) Re = 1'($urandom_range(0, 1));
            else if ($urandom_range(0, 3) != 0) Re = (R == 3'b000);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
